// File: rtl/decoder_bus_arbiter_if.sv
// Bus bundle between the requesters and the decoder arbiter.
// The master side drives requests; the slave side (the arbiter) drives grant and decoder controls.
interface decoder_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [3*N_REQ-1:0] req_adr;
    logic [N_REQ-1:0]   done;
    logic [N_REQ-1:0]   gnt;
    logic               adr0;
    logic               adr1;
    logic               adr2;
    logic               valid;
    logic               busy;
    logic               timeout_err;

    modport master (
        output req, req_adr, done,
        input  gnt, adr0, adr1, adr2, valid, busy, timeout_err
    );

    modport slave (
        input  req, req_adr, done,
        output gnt, adr0, adr1, adr2, valid, busy, timeout_err
    );
endinterface

// File: rtl/decoder_bus_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 address decoder among N_REQ requesters.
// One requester owns the decoder per access; release on done, withdrawal or timeout.
module decoder_bus_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    decoder_bus_arbiter_if.slave bus
);

    localparam int            PW     = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam bit            TO_EN  = (TIMEOUT != 0);
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [PW-1:0]     ptr_r;
    logic [PW-1:0]     ptr_s;
    logic [PW-1:0]     gidx_r;
    logic [PW-1:0]     gidx_s;
    logic [PW-1:0]     pick_s;
    logic [PW-1:0]     idx_s;
    logic [TW-1:0]     timer_r;
    logic [TW-1:0]     timer_s;
    logic [2:0]        addr_r;
    logic [2:0]        addr_s;
    logic [2:0]        pick_addr_s;
    logic              found_s;
    logic              forced_s;
    logic [N_REQ-1:0]  gnt_r;
    logic [N_REQ-1:0]  gnt_s;
    logic              valid_r;
    logic              busy_r;
    logic              terr_r;

    // Round-robin search: first pending request at or after ptr, wrapping at N_REQ
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        idx_s   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx_s = PW'((int'(ptr_r) + i) % N_REQ);
            if (!found_s && bus.req[idx_s]) begin
                found_s = 1'b1;
                pick_s  = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Select the winning requester's address slice
    always_comb begin
        pick_addr_s = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (PW'(i) == pick_s) begin
                pick_addr_s = bus.req_adr[3*i +: 3];
            end else begin
                pick_addr_s = pick_addr_s;
            end
        end
    end

    // Next-state logic; done/withdrawal takes priority so a coincident expiry is not an error
    always_comb begin
        state_s  = state_r;
        ptr_s    = ptr_r;
        gidx_s   = gidx_r;
        timer_s  = timer_r;
        addr_s   = addr_r;
        forced_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_s = ST_ACTIVE;
                    gidx_s  = pick_s;
                    addr_s  = pick_addr_s;
                    timer_s = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                timer_s = timer_r + TW'(1);
                if (bus.done[gidx_r] || !bus.req[gidx_r]) begin
                    state_s = ST_RELEASE;
                end else if (TO_EN && (timer_r == T_LAST)) begin
                    state_s  = ST_RELEASE;
                    forced_s = 1'b1;
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            ST_RELEASE: begin
                state_s = ST_IDLE;
                if (int'(gidx_r) == (N_REQ - 1)) begin
                    ptr_s = '0;
                end else begin
                    ptr_s = gidx_r + PW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // One-hot grant for the upcoming cycle
    always_comb begin
        gnt_s = '0;
        if (state_s == ST_ACTIVE) begin
            gnt_s[gidx_s] = 1'b1;
        end else begin
            gnt_s = '0;
        end
    end

    // State, bookkeeping and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            gidx_r  <= '0;
            timer_r <= '0;
            addr_r  <= 3'd0;
            gnt_r   <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            terr_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            gidx_r  <= gidx_s;
            timer_r <= timer_s;
            addr_r  <= addr_s;
            gnt_r   <= gnt_s;
            valid_r <= (state_s == ST_ACTIVE);
            busy_r  <= (state_s != ST_IDLE);
            terr_r  <= forced_s;
        end
    end

    assign bus.gnt         = gnt_r;
    assign bus.adr0        = addr_r[2];
    assign bus.adr1        = addr_r[1];
    assign bus.adr2        = addr_r[0];
    assign bus.valid       = valid_r;
    assign bus.busy        = busy_r;
    assign bus.timeout_err = terr_r;

endmodule

// File: tb/tb_decoder_bus_arbiter.sv
// Randomized and directed bench for decoder_bus_arbiter against an ownership-level reference model.
module tb_decoder_bus_arbiter;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 15;
    localparam int TW      = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decoder_bus_arbiter_if #(.N_REQ(N_REQ)) bus ();

    decoder_bus_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the decoder, for how long, and whether we are in turnaround
    int         m_owner;
    int         m_age;
    int         m_next;
    bit         m_rel;
    bit         m_forced;
    logic [2:0] m_addr;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_age    = 0;
        m_next   = 0;
        m_rel    = 1'b0;
        m_forced = 1'b0;
        m_addr   = 3'd0;
    endtask

    task automatic model_edge();
        if (m_rel) begin
            m_rel    = 1'b0;
            m_forced = 1'b0;
        end else if (m_owner < 0) begin
            for (int i = 0; i < N_REQ; i++) begin
                int c;
                c = (m_next + i) % N_REQ;
                if (bus.req[c]) begin
                    m_owner = c;
                    m_age   = 0;
                    m_addr  = bus.req_adr[3*c +: 3];
                    break;
                end
            end
        end else begin
            if (bus.done[m_owner] || !bus.req[m_owner]) begin
                m_rel    = 1'b1;
                m_forced = 1'b0;
            end else if (TIMEOUT != 0 && m_age + 1 == TIMEOUT) begin
                m_rel    = 1'b1;
                m_forced = 1'b1;
            end else begin
                m_age++;
            end
            if (m_rel) begin
                m_next  = (m_owner + 1) % N_REQ;
                m_owner = -1;
            end
        end
    endtask

    task automatic compare_all();
        logic [N_REQ-1:0] exp_gnt;
        exp_gnt = '0;
        if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
        check_value("gnt", 32'(bus.gnt), 32'(exp_gnt));
        check_value("valid", 32'(bus.valid), 32'(m_owner >= 0));
        check_value("busy", 32'(bus.busy), 32'((m_owner >= 0) || m_rel));
        check_value("timeout_err", 32'(bus.timeout_err), 32'(m_rel && m_forced));
        if (m_owner >= 0) begin
            check_value("adr", 32'({bus.adr0, bus.adr1, bus.adr2}), 32'(m_addr));
        end
    endtask

    // Apply inputs at the falling edge, step the model at the rising edge, compare just after it
    task automatic cycle(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] d,
                         input logic [3*N_REQ-1:0] a);
        bus.req     = r;
        bus.done    = d;
        bus.req_adr = a;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before the next clock edge
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [N_REQ-1:0]   r_s;
    logic [N_REQ-1:0]   d_s;
    logic [3*N_REQ-1:0] a_s;
    logic [N_REQ-1:0]   prev_gnt;
    int                 order_q[$];
    int                 valid_cnt;
    int                 terr_cnt;
    bit                 seen_to;
    logic [N_REQ-1:0]   post_gnt;

    initial begin
        bus.req     = '0;
        bus.done    = '0;
        bus.req_adr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset: nothing granted, busy stays low
        repeat (3) cycle(4'b0000, 4'b0000, 12'h000);

        // Single access, address 5, done on third active cycle
        cycle(4'b0001, 4'b0000, 12'h005);
        check_value("t2_adr", 32'({bus.adr0, bus.adr1, bus.adr2}), 32'd5);
        cycle(4'b0001, 4'b0000, 12'h005);
        cycle(4'b0001, 4'b0001, 12'h005);
        repeat (3) cycle(4'b0000, 4'b0000, 12'h000);

        // Address change and foreign done ignored, then withdrawal releases without error
        do_reset();
        cycle(4'b0010, 4'b0000, 12'h030);
        cycle(4'b0010, 4'b0100, 12'h008);
        check_value("t5_adr", 32'({bus.adr0, bus.adr1, bus.adr2}), 32'd6);
        check_value("t5_gnt", 32'(bus.gnt), 32'd2);
        cycle(4'b0000, 4'b0000, 12'h008);
        check_value("t5_terr", 32'(bus.timeout_err), 32'd0);
        cycle(4'b0000, 4'b0000, 12'h000);

        // done coincident with timer expiry is a normal release
        terr_cnt = 0;
        cycle(4'b0001, 4'b0000, 12'h003);
        for (int k = 0; k < TIMEOUT - 1; k++) cycle(4'b0001, 4'b0000, 12'h003);
        cycle(4'b0001, 4'b0001, 12'h003);
        if (bus.timeout_err) terr_cnt++;
        cycle(4'b0000, 4'b0000, 12'h000);
        if (bus.timeout_err) terr_cnt++;
        check_value("t6_no_terr", 32'(terr_cnt), 32'd0);

        // Async reset while active, search restarts at requester 0
        cycle(4'b0100, 4'b0000, 12'h700);
        cycle(4'b0100, 4'b0000, 12'h700);
        do_reset();
        cycle(4'b1111, 4'b0000, 12'h123);
        check_value("t6_gnt_after_rst", 32'(bus.gnt), 32'd1);

        // Round-robin order with all requesters pending
        do_reset();
        prev_gnt = '0;
        order_q.delete();
        for (int k = 0; k < 24; k++) begin
            d_s = '0;
            if (m_owner >= 0 && m_age >= 1) d_s[m_owner] = 1'b1;
            cycle(4'b1111, d_s, 12'($urandom));
            if (bus.gnt != '0 && prev_gnt == '0) begin
                for (int j = 0; j < N_REQ; j++) if (bus.gnt[j]) order_q.push_back(j);
            end
            prev_gnt = bus.gnt;
        end
        check_value("t3_ngrants", 32'(order_q.size() >= 5), 32'd1);
        for (int k = 0; k < 5 && k < order_q.size(); k++) begin
            check_value("t3_order", 32'(order_q[k]), 32'(k % N_REQ));
        end

        // Forced timeout on requester 2, then requester 3 is next
        do_reset();
        valid_cnt = 0;
        seen_to   = 1'b0;
        post_gnt  = '0;
        for (int k = 0; k < 22; k++) begin
            cycle(4'b1100, 4'b0000, 12'($urandom));
            if (!seen_to && bus.valid) valid_cnt++;
            if (bus.timeout_err) seen_to = 1'b1;
            if (seen_to && post_gnt == '0 && bus.gnt != '0) post_gnt = bus.gnt;
        end
        check_value("t4_valid_cycles", 32'(valid_cnt), 32'(TIMEOUT));
        check_value("t4_seen_timeout", 32'(seen_to), 32'd1);
        check_value("t4_next_gnt", 32'(post_gnt), 32'b1000);

        // Randomized traffic with sparse request toggles, stray done pulses and resets
        do_reset();
        r_s = '0;
        for (int k = 0; k < 600; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if ($urandom_range(0, 7) == 0) r_s[j] = ~r_s[j];
            end
            d_s = '0;
            if ($urandom_range(0, 5) == 0) d_s[$urandom_range(0, N_REQ - 1)] = 1'b1;
            a_s = 12'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle(r_s, d_s, a_s);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
